rip_axi_line_adapter: RTL
=========================

Name: rip_axi_line_adapter

Overview:
- Word-granularity load/store front end that sits directly upstream of rip_axi_master and drives its write and read access ports.
- Converts single-word CPU/LSU requests into line-aligned burst requests of DATA_WIDTH*BURST_LEN bits.
- Extracts the target word from each returned line and returns one response per request.
- Optionally holds one line as a read buffer so repeated loads to the same line skip the bus.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width; equals the downstream beat width.
- BURST_LEN, 4, words per line; must be a power of two, at least 1.
- Derived: LINE_W = DATA_WIDTH*BURST_LEN; STRB_W = LINE_W/B_WIDTH (B_WIDTH from rip_const, 8); OFF = log2(LINE_W/8); WOFF = log2(DATA_WIDTH/8).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  high in IDLE only.
- req_addr  in  ADDR_WIDTH  byte address; low WOFF bits ignored.
- req_we  in  1  1 = store, 0 = load.
- req_wdata  in  DATA_WIDTH  store data.
- req_wstrb  in  DATA_WIDTH/8  store byte enables.
- inv  in  1  invalidate the line buffer.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  DATA_WIDTH  load data; 0 for stores.
- m_wready  in  1  downstream write port idle.
- m_waddr  out  ADDR_WIDTH  line-aligned write address.
- m_wdata  out  LINE_W  write line.
- m_wstrb  out  STRB_W  write line strobes.
- m_wvalid  out  1  write request.
- m_wdone  in  1  write complete pulse.
- m_rready  in  1  downstream read port idle.
- m_raddr  out  ADDR_WIDTH  line-aligned read address.
- m_rvalid  out  1  read request.
- m_rdata  in  LINE_W  returned line.
- m_rdone  in  1  read complete pulse.

Behaviour:
- Reset: one clock, synchronous, active-high; rst=1 at a clock edge forces IDLE. Reset values:
  - resp_valid, m_wvalid, m_rvalid: 0.
  - m_waddr, m_wdata, m_wstrb, m_raddr, resp_rdata: 0.
  - line buffer invalid.
- Reset mid-operation abandons the transaction and sends no response. rip_axi_master must be reset in the same cycle (its rstn = ~rst).
- States:
  - IDLE: req_ready=1. On req_valid, latch addr, we, wdata, wstrb and word index widx = addr[OFF-1:WOFF].
    - Store: go to WR_REQ.
    - Load with buffer hit: go to RESP.
    - Load otherwise: go to RD_REQ.
  - WR_REQ: drive m_waddr = {addr[ADDR_WIDTH-1:OFF], 0}; m_wdata = req_wdata replicated BURST_LEN times; m_wstrb = req_wstrb at lanes [widx*DATA_WIDTH/8 +: DATA_WIDTH/8], all other bits 0; m_wvalid=1. On m_wvalid && m_wready, drop m_wvalid and go to WR_WAIT.
  - WR_WAIT: on m_wdone, set resp_valid=1, resp_rdata=0, go to IDLE.
  - RD_REQ: drive m_raddr line-aligned, m_rvalid=1. On m_rvalid && m_rready, drop m_rvalid and go to RD_WAIT.
  - RD_WAIT: on m_rdone, set resp_rdata = m_rdata[widx*DATA_WIDTH +: DATA_WIDTH] and resp_valid=1, go to IDLE.
  - RESP (hit path): set resp_valid=1 with the buffered word, go to IDLE.
- Handshake rules:
  - m_wvalid/m_rvalid are registered and held until handshake; address and data stay stable while valid.
  - m_wdone/m_rdone seen outside the matching WAIT state are ignored.
- Timing:
  - resp_valid is high exactly one cycle, the cycle after the done pulse (or after RESP entry).
  - Earliest next request acceptance is the same cycle resp_valid is high, since the FSM is back in IDLE.
  - One outstanding request; no reordering.
- Address wrap: line alignment only clears the low OFF bits; no carry.

Optional Feature:
- Macro: RIP_AXI_LINE_BUF_EN.
- Defined: one-entry line buffer (tag = addr[ADDR_WIDTH-1:OFF], LINE_W data, valid bit).
  - Filled on every RD_WAIT completion.
  - Load hit: response 2 cycles after acceptance, no m_rvalid.
  - Store whose tag matches: merges req_wdata bytes into the buffer at m_wdone (write-through).
  - inv=1 in any cycle clears valid; if inv coincides with a fill, inv wins.
- Undefined: no buffer; every load goes through RD_REQ; inv ignored.

Test Plan (BURST_LEN=4, DATA_WIDTH=32):
- Load 0x0000_1008, line returned 0x44444444_33333333_22222222_11111111 -> m_raddr=0x0000_1000, resp_rdata=0x33333333, resp_valid one cycle after m_rdone.
- Store 0x0000_2004, wdata 0xCAFEBABE, wstrb 4'b0011 -> m_waddr=0x0000_2000, m_wdata = 4x 0xCAFEBABE, m_wstrb=16'h0030, resp_valid with resp_rdata=0 after m_wdone.
- m_rready held low 5 cycles after a load -> m_rvalid and m_raddr stable for all 5 cycles; exactly one handshake.
- rst asserted in RD_WAIT, later m_rdone pulse -> no resp_valid; next load re-issues m_rvalid.
- RIP_AXI_LINE_BUF_EN: load 0x1008 then load 0x100C -> second load has no m_rvalid, resp_rdata=0x44444444 two cycles after acceptance.
- RIP_AXI_LINE_BUF_EN: then store 0x100C wdata 0x000000AA strb 4'b0001, then load 0x100C -> 0x444444AA from buffer; after an inv pulse, a third load to 0x100C re-issues m_rvalid.

Source files
------------

// File: rtl/rip_axi_line_adapter.sv
// rip_axi_line_adapter: converts single-word load/store requests into
// line-aligned burst requests for rip_axi_master and returns one word per request.
// Optional feature macro: RIP_AXI_LINE_BUF_EN (one-entry write-through line buffer).
module rip_axi_line_adapter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   req_valid,
    output logic                                   req_ready,
    input  logic [ADDR_WIDTH-1:0]                  req_addr,
    input  logic                                   req_we,
    input  logic [DATA_WIDTH-1:0]                  req_wdata,
    input  logic [DATA_WIDTH/8-1:0]                req_wstrb,
    input  logic                                   inv,
    output logic                                   resp_valid,
    output logic [DATA_WIDTH-1:0]                  resp_rdata,
    input  logic                                   m_wready,
    output logic [ADDR_WIDTH-1:0]                  m_waddr,
    output logic [DATA_WIDTH*BURST_LEN-1:0]        m_wdata,
    output logic [DATA_WIDTH*BURST_LEN/8-1:0]      m_wstrb,
    output logic                                   m_wvalid,
    input  logic                                   m_wdone,
    input  logic                                   m_rready,
    output logic [ADDR_WIDTH-1:0]                  m_raddr,
    output logic                                   m_rvalid,
    input  logic [DATA_WIDTH*BURST_LEN-1:0]        m_rdata,
    input  logic                                   m_rdone
);
    localparam int B_WIDTH = 8;
    localparam int LINE_W  = DATA_WIDTH * BURST_LEN;
    localparam int STRB_W  = LINE_W / B_WIDTH;
    localparam int BPW     = DATA_WIDTH / B_WIDTH;
    localparam int OFF     = $clog2(LINE_W / 8);
    localparam int WOFF    = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int TAG_W   = ADDR_WIDTH - OFF;

    typedef enum logic [2:0] {S_IDLE, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        widx_q, widx_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
    logic                    m_wvalid_q, m_wvalid_d;
    logic [ADDR_WIDTH-1:0]   m_waddr_q, m_waddr_d;
    logic [LINE_W-1:0]       m_wdata_q, m_wdata_d;
    logic [STRB_W-1:0]       m_wstrb_q, m_wstrb_d;
    logic                    m_rvalid_q, m_rvalid_d;
    logic [ADDR_WIDTH-1:0]   m_raddr_q, m_raddr_d;

    logic [IDX_W-1:0]        req_widx;
    logic [TAG_W-1:0]        req_tag;
    logic [ADDR_WIDTH-1:0]   req_line_addr;
    logic                    hit;

    // Word index within the line; BURST_LEN=1 degenerates to index 0.
    assign req_widx      = IDX_W'((req_addr >> WOFF) & ADDR_WIDTH'(BURST_LEN - 1));
    assign req_tag       = req_addr[ADDR_WIDTH-1:OFF];
    assign req_line_addr = {req_tag, {OFF{1'b0}}};

`ifdef RIP_AXI_LINE_BUF_EN
    logic [TAG_W-1:0]        tag_q, tag_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [BPW-1:0]          wstrb_q, wstrb_d;
    logic                    buf_vld_q, buf_vld_d;
    logic [TAG_W-1:0]        buf_tag_q, buf_tag_d;
    logic [LINE_W-1:0]       buf_data_q, buf_data_d;

    // A same-cycle invalidate makes the buffer unusable for the incoming load.
    assign hit = buf_vld_q && !inv && (buf_tag_q == req_tag);
`else
    logic unused_inv;
    assign unused_inv = inv;
    assign hit        = 1'b0;
`endif

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            widx_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            m_wvalid_q   <= 1'b0;
            m_waddr_q    <= '0;
            m_wdata_q    <= '0;
            m_wstrb_q    <= '0;
            m_rvalid_q   <= 1'b0;
            m_raddr_q    <= '0;
`ifdef RIP_AXI_LINE_BUF_EN
            tag_q        <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            buf_vld_q    <= 1'b0;
            buf_tag_q    <= '0;
            buf_data_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            widx_q       <= widx_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            m_wvalid_q   <= m_wvalid_d;
            m_waddr_q    <= m_waddr_d;
            m_wdata_q    <= m_wdata_d;
            m_wstrb_q    <= m_wstrb_d;
            m_rvalid_q   <= m_rvalid_d;
            m_raddr_q    <= m_raddr_d;
`ifdef RIP_AXI_LINE_BUF_EN
            tag_q        <= tag_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            buf_vld_q    <= buf_vld_d;
            buf_tag_q    <= buf_tag_d;
            buf_data_q   <= buf_data_d;
`endif
        end
    end

    // Next-state logic: request capture, downstream handshakes and response pulse.
    always_comb begin
        state_d      = state_q;
        widx_d       = widx_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        m_wvalid_d   = m_wvalid_q;
        m_waddr_d    = m_waddr_q;
        m_wdata_d    = m_wdata_q;
        m_wstrb_d    = m_wstrb_q;
        m_rvalid_d   = m_rvalid_q;
        m_raddr_d    = m_raddr_q;
`ifdef RIP_AXI_LINE_BUF_EN
        tag_d        = tag_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        buf_vld_d    = buf_vld_q;
        buf_tag_d    = buf_tag_q;
        buf_data_d   = buf_data_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    widx_d = req_widx;
`ifdef RIP_AXI_LINE_BUF_EN
                    tag_d   = req_tag;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
`endif
                    if (req_we) begin
                        state_d    = S_WR_REQ;
                        m_wvalid_d = 1'b1;
                        m_waddr_d  = req_line_addr;
                        m_wdata_d  = {BURST_LEN{req_wdata}};
                        m_wstrb_d  = STRB_W'(req_wstrb) << (int'(req_widx) * BPW);
                    end else if (hit) begin
                        state_d = S_RESP;
                    end else begin
                        state_d    = S_RD_REQ;
                        m_rvalid_d = 1'b1;
                        m_raddr_d  = req_line_addr;
                    end
                end
            end
            S_WR_REQ: begin
                if (m_wready) begin
                    m_wvalid_d = 1'b0;
                    state_d    = S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (m_wdone) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = '0;
                    state_d      = S_IDLE;
`ifdef RIP_AXI_LINE_BUF_EN
                    // Write-through: keep the buffered line coherent with the store.
                    if (buf_vld_q && (buf_tag_q == tag_q)) begin
                        for (int b = 0; b < BPW; b++) begin
                            if (wstrb_q[b]) begin
                                buf_data_d[int'(widx_q)*DATA_WIDTH + b*B_WIDTH +: B_WIDTH] =
                                    wdata_q[b*B_WIDTH +: B_WIDTH];
                            end
                        end
                    end
`endif
                end
            end
            S_RD_REQ: begin
                if (m_rready) begin
                    m_rvalid_d = 1'b0;
                    state_d    = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (m_rdone) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = m_rdata[int'(widx_q)*DATA_WIDTH +: DATA_WIDTH];
                    state_d      = S_IDLE;
`ifdef RIP_AXI_LINE_BUF_EN
                    buf_vld_d  = 1'b1;
                    buf_tag_d  = tag_q;
                    buf_data_d = m_rdata;
`endif
                end
            end
            S_RESP: begin
                resp_valid_d = 1'b1;
`ifdef RIP_AXI_LINE_BUF_EN
                resp_rdata_d = buf_data_q[int'(widx_q)*DATA_WIDTH +: DATA_WIDTH];
`else
                resp_rdata_d = '0;
`endif
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef RIP_AXI_LINE_BUF_EN
        // Invalidate overrides a fill landing in the same cycle.
        if (inv) buf_vld_d = 1'b0;
`endif
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign m_wvalid   = m_wvalid_q;
    assign m_waddr    = m_waddr_q;
    assign m_wdata    = m_wdata_q;
    assign m_wstrb    = m_wstrb_q;
    assign m_rvalid   = m_rvalid_q;
    assign m_raddr    = m_raddr_q;

endmodule
